// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage of the pipelined RISC-V core. Owns the PC, drives a
// byte address to the combinational instruction memory and captures the
// returned word into the IF/ID pipeline register. Handles stall, branch/jump
// redirect with flush, and halts fetch on a zero word or at the last word of
// the memory range.
//
// Optional feature macro: FETCH_PERF_EN
//   When defined, adds the fetch_count and stall_count performance counters.
//
// Ports:
//   clk             in   1   system clock, rising-edge
//   reset           in   1   asynchronous active-high reset
//   pc              out  32  byte address to instruction memory (word aligned)
//   instruction     in   32  word returned combinationally for pc
//   stall           in   1   hazard hold: freezes PC and IF/ID
//   redirect_valid  in   1   taken branch/jump from a later stage
//   redirect_target in   32  new fetch address when redirect_valid=1
//   if_id_valid     out  1   IF/ID holds a real instruction (0 = bubble)
//   if_id_instr     out  32  captured instruction word
//   if_id_pc        out  32  address the captured word was fetched from
//   if_id_pc_plus4  out  32  if_id_pc + 4 (link value)
//   halted          out  1   fetch FSM is in HALTED
//   misalign_err    out  1   sticky: a redirect target had nonzero bits [1:0]
//   fetch_count     out  32  (FETCH_PERF_EN) instructions captured as valid
//   stall_count     out  32  (FETCH_PERF_EN) stalled cycles while running
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NUM_INST = 128
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        halted,
    output logic        misalign_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    localparam logic [0:0]  ST_RUN    = 1'b0;
    localparam logic [0:0]  ST_HALTED = 1'b1;
    localparam logic [31:0] LAST_PC   = 32'((NUM_INST - 32'd1) * 32'd4);

    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic        r_if_id_valid;
    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_pc_plus4;
    logic        r_misalign_err;

    logic [0:0]  w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_valid_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_if_pc_nxt;
    logic [31:0] w_pc_plus4_nxt;
    logic        w_misalign_nxt;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = r_pc + 32'd4;

    // Next-state decode: redirect beats stall beats a normal fetch.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_valid_nxt    = r_if_id_valid;
        w_instr_nxt    = r_if_id_instr;
        w_if_pc_nxt    = r_if_id_pc;
        w_pc_plus4_nxt = r_if_id_pc_plus4;
        w_misalign_nxt = r_misalign_err;
        if (redirect_valid) begin
            // Flush the wrong-path word; a redirect also cancels any halt.
            w_pc_nxt    = {redirect_target[31:2], 2'b00};
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_RUN;
            if (redirect_target[1:0] != 2'b00) begin
                w_misalign_nxt = 1'b1;
            end else begin
                w_misalign_nxt = r_misalign_err;
            end
        end else if (stall) begin
            w_state_nxt = r_state;
        end else begin
            case (r_state)
                ST_RUN: begin
                    w_instr_nxt    = instruction;
                    w_if_pc_nxt    = r_pc;
                    w_pc_plus4_nxt = w_pc_plus4;
                    if (instruction == 32'd0) begin
                        // End of program: pc keeps pointing at the zero word.
                        w_valid_nxt = 1'b0;
                        w_state_nxt = ST_HALTED;
                    end else if (r_pc == LAST_PC) begin
                        // Last word of memory: deliver it, then stop.
                        w_valid_nxt = 1'b1;
                        w_state_nxt = ST_HALTED;
                    end else begin
                        w_valid_nxt = 1'b1;
                        w_pc_nxt    = w_pc_plus4;
                    end
                end
                ST_HALTED: begin
                    w_valid_nxt = 1'b0;
                end
                default: begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // PC, FSM state and IF/ID pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= ST_RUN;
            r_pc             <= RESET_PC;
            r_if_id_valid    <= 1'b0;
            r_if_id_instr    <= 32'd0;
            r_if_id_pc       <= 32'd0;
            r_if_id_pc_plus4 <= 32'd4;
            r_misalign_err   <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_pc             <= w_pc_nxt;
            r_if_id_valid    <= w_valid_nxt;
            r_if_id_instr    <= w_instr_nxt;
            r_if_id_pc       <= w_if_pc_nxt;
            r_if_id_pc_plus4 <= w_pc_plus4_nxt;
            r_misalign_err   <= w_misalign_nxt;
        end
    end

    assign pc             = r_pc;
    assign if_id_valid    = r_if_id_valid;
    assign if_id_instr    = r_if_id_instr;
    assign if_id_pc       = r_if_id_pc;
    assign if_id_pc_plus4 = r_if_id_pc_plus4;
    assign halted         = (r_state == ST_HALTED);
    assign misalign_err   = r_misalign_err;

`ifdef FETCH_PERF_EN
    logic        w_fetch_inc;
    logic        w_stall_inc;
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    // A fetch counts exactly when a normal RUN cycle loads a nonzero word.
    assign w_fetch_inc = !redirect_valid && !stall && (r_state == ST_RUN)
                         && (instruction != 32'd0);
    assign w_stall_inc = !redirect_valid && stall && (r_state == ST_RUN);

    // Free-running performance counters, wrapping modulo 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_count <= 32'd0;
            r_stall_count <= 32'd0;
        end else begin
            if (w_fetch_inc) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end else begin
                r_fetch_count <= r_fetch_count;
            end
            if (w_stall_inc) begin
                r_stall_count <= r_stall_count + 32'd1;
            end else begin
                r_stall_count <= r_stall_count;
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. Two instances share clock, reset and the
// stall/redirect inputs: dut (NUM_INST=128) and dut4 (NUM_INST=4, all-nonzero
// memory, exercising the end-of-range halt). A behavioural reference model
// tracks both; directed table rows also carry hand-derived expected values.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] ifpc;
        logic [31:0] p4;
        logic        halt;
        logic        mis;
        logic [31:0] fc;
        logic [31:0] sc;
    } mstate_t;

    typedef struct {
        bit          s;
        bit          rv;
        logic [31:0] rt;
        logic [31:0] e_pc;
        bit          e_valid;
        logic [31:0] e_ifpc;
        bit          e_halt;
        bit          e_mis;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        rv;
    logic [31:0] rt;

    logic [31:0] pc, instruction, if_id_instr, if_id_pc, if_id_pc_plus4;
    logic        if_id_valid, halted, misalign_err;
    logic [31:0] pc4, instruction4, if_id_instr4, if_id_pc4, if_id_pc_plus44;
    logic        if_id_valid4, halted4, misalign_err4;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count, stall_count, fetch_count4, stall_count4;
`endif

    logic [31:0] mem  [0:127];
    logic [31:0] mem4 [0:3];

    assign instruction  = mem[pc[8:2]];
    assign instruction4 = mem4[pc4[3:2]];

    mstate_t m, m4;
    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .NUM_INST(128)) dut (
        .clk(clk), .reset(reset), .pc(pc), .instruction(instruction),
        .stall(stall), .redirect_valid(rv), .redirect_target(rt),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4),
        .halted(halted), .misalign_err(misalign_err)
`ifdef FETCH_PERF_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    fetch_unit #(.RESET_PC(32'h0000_0000), .NUM_INST(4)) dut4 (
        .clk(clk), .reset(reset), .pc(pc4), .instruction(instruction4),
        .stall(stall), .redirect_valid(rv), .redirect_target(rt),
        .if_id_valid(if_id_valid4), .if_id_instr(if_id_instr4),
        .if_id_pc(if_id_pc4), .if_id_pc_plus4(if_id_pc_plus44),
        .halted(halted4), .misalign_err(misalign_err4)
`ifdef FETCH_PERF_EN
        , .fetch_count(fetch_count4), .stall_count(stall_count4)
`endif
    );

    function automatic mstate_t model_reset();
        mstate_t r;
        r.pc = 32'd0; r.valid = 1'b0; r.instr = 32'd0; r.ifpc = 32'd0;
        r.p4 = 32'd4; r.halt = 1'b0; r.mis = 1'b0; r.fc = 32'd0; r.sc = 32'd0;
        return r;
    endfunction

    // One clock edge of the fetch stage described by its rules.
    function automatic mstate_t model_step(mstate_t c, bit s, bit r,
                                           logic [31:0] t, logic [31:0] w,
                                           logic [31:0] last);
        mstate_t n = c;
        if (r) begin
            n.pc    = t & 32'hFFFF_FFFC;
            n.valid = 1'b0;
            n.halt  = 1'b0;
            if (t[1:0] != 2'b00) n.mis = 1'b1;
        end else if (s) begin
            if (!c.halt) n.sc = c.sc + 32'd1;
        end else if (c.halt) begin
            n.valid = 1'b0;
        end else begin
            n.instr = w;
            n.ifpc  = c.pc;
            n.p4    = c.pc + 32'd4;
            if (w == 32'd0) begin
                n.valid = 1'b0;
                n.halt  = 1'b1;
            end else begin
                n.valid = 1'b1;
                n.fc    = c.fc + 32'd1;
                if (c.pc == last) n.halt = 1'b1;
                else              n.pc   = c.pc + 32'd4;
            end
        end
        return n;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_model(string tag);
        chk({tag, ".pc"},     pc,                    m.pc);
        chk({tag, ".valid"},  32'(if_id_valid),      32'(m.valid));
        chk({tag, ".instr"},  if_id_instr,           m.instr);
        chk({tag, ".ifpc"},   if_id_pc,              m.ifpc);
        chk({tag, ".p4"},     if_id_pc_plus4,        m.p4);
        chk({tag, ".halted"}, 32'(halted),           32'(m.halt));
        chk({tag, ".mis"},    32'(misalign_err),     32'(m.mis));
        chk({tag, ".u4.pc"},     pc4,                m4.pc);
        chk({tag, ".u4.valid"},  32'(if_id_valid4),  32'(m4.valid));
        chk({tag, ".u4.instr"},  if_id_instr4,       m4.instr);
        chk({tag, ".u4.ifpc"},   if_id_pc4,          m4.ifpc);
        chk({tag, ".u4.p4"},     if_id_pc_plus44,    m4.p4);
        chk({tag, ".u4.halted"}, 32'(halted4),       32'(m4.halt));
        chk({tag, ".u4.mis"},    32'(misalign_err4), 32'(m4.mis));
`ifdef FETCH_PERF_EN
        chk({tag, ".fcnt"},    fetch_count,  m.fc);
        chk({tag, ".scnt"},    stall_count,  m.sc);
        chk({tag, ".u4.fcnt"}, fetch_count4, m4.fc);
        chk({tag, ".u4.scnt"}, stall_count4, m4.sc);
`endif
    endtask

    task automatic chk_reset(string tag);
        chk({tag, ".pc"},       pc,                    32'd0);
        chk({tag, ".valid"},    32'(if_id_valid),      32'd0);
        chk({tag, ".instr"},    if_id_instr,           32'd0);
        chk({tag, ".ifpc"},     if_id_pc,              32'd0);
        chk({tag, ".p4"},       if_id_pc_plus4,        32'd4);
        chk({tag, ".halted"},   32'(halted),           32'd0);
        chk({tag, ".mis"},      32'(misalign_err),     32'd0);
        chk({tag, ".u4.pc"},    pc4,                   32'd0);
        chk({tag, ".u4.valid"}, 32'(if_id_valid4),     32'd0);
        chk({tag, ".u4.p4"},    if_id_pc_plus44,       32'd4);
        chk({tag, ".u4.halt"},  32'(halted4),          32'd0);
`ifdef FETCH_PERF_EN
        chk({tag, ".fcnt"},     fetch_count,           32'd0);
        chk({tag, ".scnt"},     stall_count,           32'd0);
        chk({tag, ".u4.fcnt"},  fetch_count4,          32'd0);
`endif
    endtask

    // Drive one cycle of inputs, advance both models, compare after the edge.
    task automatic step(bit s, bit r, logic [31:0] t, string tag);
        stall = s;
        rv    = r;
        rt    = t;
        m  = model_step(m,  s, r, t, mem[m.pc[8:2]],   32'd508);
        m4 = model_step(m4, s, r, t, mem4[m4.pc[3:2]], 32'd12);
        @(posedge clk);
        #1;
        chk_model(tag);
    endtask

    vec_t vecs [16];

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        rv    = 1'b0;
        rt    = 32'd0;
        mem[0] = 32'h0040_0293;
        mem[1] = 32'h4567_8337;
        mem[2] = 32'h1233_0313;
        mem[3] = 32'h0000_0000;
        for (int i = 4; i < 128; i++) mem[i] = 32'h0000_0013 + (i << 20);
        mem[12] = 32'h0000_0000;
        for (int i = 0; i < 4; i++) mem4[i] = 32'h1000_0001 + i;

        // Directed rows after the first halt; expected values derived by hand.
        vecs[0]  = '{1'b1, 1'b0, 32'h00, 32'h0C, 1'b0, 32'h0C, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'h08, 32'h08, 1'b0, 32'h0C, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h00, 32'h08, 1'b0, 32'h0C, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h00, 32'h08, 1'b0, 32'h0C, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h00, 32'h08, 1'b0, 32'h0C, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h00, 32'h0C, 1'b1, 32'h08, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 32'h24, 32'h24, 1'b0, 32'h08, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h2C, 32'h2C, 1'b0, 32'h08, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 32'h00, 32'h30, 1'b1, 32'h2C, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'h00, 32'h30, 1'b0, 32'h30, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 32'h04, 32'h04, 1'b0, 32'h30, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'h16, 32'h14, 1'b0, 32'h30, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 32'h00, 32'h18, 1'b1, 32'h14, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 32'h30, 32'h30, 1'b0, 32'h14, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 32'h08, 32'h08, 1'b0, 32'h14, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 32'h00, 32'h0C, 1'b1, 32'h08, 1'b0, 1'b1};

        repeat (2) @(posedge clk);
        #3;
        chk_reset("por");
        reset = 1'b0;
        m  = model_reset();
        m4 = model_reset();

        // Free run to the zero word at 12; dut4 halts on its last word.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'd0, "run");
            chk("run.ifpc_seq", if_id_pc, 32'(i * 4));
            chk("run.valid_seq", 32'(if_id_valid), 32'd1);
        end
        step(1'b0, 1'b0, 32'd0, "halt");
        chk("halt.valid",     32'(if_id_valid),  32'd0);
        chk("halt.halted",    32'(halted),       32'd1);
        chk("halt.pc",        pc,                32'h0C);
        chk("u4.last.pc",     pc4,               32'h0C);
        chk("u4.last.valid",  32'(if_id_valid4), 32'd1);
        chk("u4.last.ifpc",   if_id_pc4,         32'h0C);
        chk("u4.last.halted", 32'(halted4),      32'd1);
        step(1'b0, 1'b0, 32'd0, "halt2");
        chk("u4.held.pc",     pc4,               32'h0C);
        chk("u4.held.valid",  32'(if_id_valid4), 32'd0);

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].s, vecs[i].rv, vecs[i].rt, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.pc", i),     pc,                vecs[i].e_pc);
            chk($sformatf("vec%0d.valid", i),  32'(if_id_valid),  32'(vecs[i].e_valid));
            chk($sformatf("vec%0d.ifpc", i),   if_id_pc,          vecs[i].e_ifpc);
            chk($sformatf("vec%0d.halted", i), 32'(halted),       32'(vecs[i].e_halt));
            chk($sformatf("vec%0d.mis", i),    32'(misalign_err), 32'(vecs[i].e_mis));
        end
        chk("link.p4_after_2c", 32'h30, 32'h2C + 32'd4);

        // Reset asserted in the middle of a stall, away from any clock edge.
        mem[3] = 32'h0000_0013;
        step(1'b1, 1'b0, 32'd0, "prestall");
        step(1'b1, 1'b0, 32'd0, "prestall");
        #3;
        reset = 1'b1;
        #1;
        chk_reset("midrst");
        #1;
        reset = 1'b0;
        m  = model_reset();
        m4 = model_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0, "post");
        chk("post.pc", pc, 32'd20);
`ifdef FETCH_PERF_EN
        chk("post.fetch_count", fetch_count, 32'd5);
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 128; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        for (int i = 0; i < 4; i++)
            mem4[i] = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
        for (int i = 0; i < 600; i++) begin
            logic [31:0] tgt;
            tgt = 32'($urandom_range(0, 127)) << 2;
            if ($urandom_range(0, 4) == 0) tgt = 32'd496 + (32'($urandom_range(0, 3)) << 2);
            if ($urandom_range(0, 3) == 0) tgt = tgt | 32'($urandom_range(1, 3));
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, tgt, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the pipelined RISC-V core, and the requesting end of the instruction-memory interface.
- Owns the PC and drives a byte address to the combinational instruction memory.
- Captures the returned word into the IF/ID pipeline register.
- Handles stall, branch/jump redirect with flush, and halts fetch at the zero-filled end of program or at the end of the memory range.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- NUM_INST, 128, instruction memory depth in words; the last fetchable address is (NUM_INST-1)*4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc  output  32  byte address to instruction memory; bits [1:0] are always 0.
- instruction  input  32  word returned combinationally for the current pc.
- stall  input  1  hazard-unit hold request; freezes PC and IF/ID.
- redirect_valid  input  1  branch/jump taken, resolved in a later stage.
- redirect_target  input  32  new fetch address when redirect_valid=1.
- if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- if_id_instr  output  32  captured instruction word.
- if_id_pc  output  32  address the captured word was fetched from.
- if_id_pc_plus4  output  32  if_id_pc + 4, for jal/jalr link.
- halted  output  1  high while the fetch FSM is in HALTED.
- misalign_err  output  1  sticky: a redirect target had nonzero bits [1:0].

Behaviour:
- Reset (asynchronous, any state or cycle):
  - pc = RESET_PC, state = RUN.
  - if_id_valid = 0, if_id_instr = 0, if_id_pc = 0, if_id_pc_plus4 = 4.
  - halted = 0, misalign_err = 0.
- FSM states: RUN and HALTED.
- Per-edge priority: redirect_valid > stall > normal.
- Redirect (either state):
  - pc <= {redirect_target[31:2], 2'b00}.
  - if_id_valid <= 0 (flush of the wrong-path instruction).
  - state <= RUN.
  - If redirect_target[1:0] != 0, misalign_err <= 1; it stays set until reset.
- Stall (no redirect): pc, IF/ID and state all hold.
- Normal RUN cycle:
  - if_id_instr <= instruction, if_id_pc <= pc, if_id_pc_plus4 <= pc+4.
  - Zero word (instruction == 0):
    - if_id_valid <= 0 and state <= HALTED.
    - pc holds and still points at the zero word.
  - Nonzero word at pc == (NUM_INST-1)*4:
    - if_id_valid <= 1 and state <= HALTED.
    - pc holds; it does not increment past the memory range.
  - Otherwise: if_id_valid <= 1 and pc <= pc + 4 (32-bit add).
- HALTED (no redirect):
  - pc holds, if_id_valid <= 0, IF/ID data fields hold.
  - halted = 1, combinationally from state.
- Timing:
  - Fetch latency: the word at pc appears on if_id_* exactly one edge later.
  - Throughput: one instruction per cycle when not stalled.
- A zero word fetched on a speculative path is cancelled by the redirect that flushes it. Halt is therefore not final until no redirect is pending.
- Redirect and zero-word detection in the same cycle: the redirect wins, state = RUN and no halt.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds output fetch_count (32) and output stall_count (32), both reset to 0.
  - fetch_count increments on every edge where if_id_valid is written 1.
  - stall_count increments on every edge where stall=1 and redirect_valid=0 in RUN.
  - Both counters wrap modulo 2^32.
- Undefined: neither port nor either counter exists; all other behaviour is identical.

Test Plan:
- Reset, then free-run over memory {0x00400293, 0x45678337, 0x12330313, 0} -> if_id_pc is 0, 4, 8 on successive edges with if_id_valid=1; the edge after the word at 8 gives if_id_valid=0, halted=1, pc=12.
- Assert stall for 3 cycles while pc=8 -> pc stays 8, if_id_instr/if_id_pc unchanged for 3 edges; fetch resumes at 8 afterwards.
- At pc=0x24, redirect_valid=1 with target 0x2C -> next edge pc=0x2C and if_id_valid=0; the following edge gives if_id_pc=0x2C, if_id_pc_plus4=0x30.
- Redirect and stall together, and separately redirect while HALTED at pc=0x30 with target 0x04 -> redirect wins, halted drops to 0, pc=0x04.
- Redirect to target 0x0000_0016 -> pc=0x14 and misalign_err=1, which stays 1 until reset; with NUM_INST=4 and no zero words, halt occurs after capturing pc=0xC, with pc held at 0xC.
- Assert reset mid-stall with FETCH_PERF_EN defined -> all outputs return to their reset values and fetch_count=stall_count=0; after 5 unstalled fetches, fetch_count=5.
